// File: rtl/uart_rx_ext_pkg.sv
// Shared encodings for the oversampling UART receiver.
package uart_rx_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/data_sync.sv
// Two-flop synchronizer for a single asynchronous bit; resets to RST_VAL.
module data_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with majority-vote sampling, parity/stop/break checks and a
// one-deep valid/ready output register that flags overrun on dropped frames.
module uart_rx_ext
  import uart_rx_ext_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [3:0]    BI_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);

  logic rx_sync;

  data_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           vote_q, vote_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;
  logic                 overrun_q, overrun_d;
  logic                 complete;
  logic                 vote_bit;
  logic                 sample;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vote_d     = vote_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    brk_d      = brk_q;
    complete   = 1'b0;
    vote_bit   = maj3(vote_q);
    sample     = (cnt_q == CNT_LAST);

    if (baud_tick) begin
      vote_d = {vote_q[1:0], rx_sync};
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!vote_bit) begin
              state_d    = ST_DATA;
              bit_idx_d  = '0;
              par_bit_d  = 1'b0;
              par_err_d  = 1'b0;
              stop_err_d = 1'b0;
              brk_d      = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (sample) begin
            cnt_d   = '0;
            shreg_d = {vote_bit, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == BI_LAST) begin
              bit_idx_d = '0;
              state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            cnt_d     = '0;
            par_bit_d = vote_bit;
            par_err_d = vote_bit ^ (^shreg_q) ^ (PARITY == PARITY_ODD);
            state_d   = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (sample) begin
            cnt_d      = '0;
            stop_err_d = stop_err_q | ~vote_bit;
            // Break is judged on the first stop bit only.
            if (bit_idx_q == 4'd0) begin
              brk_d = (shreg_q == '0) && !par_bit_q && !vote_bit;
            end
            if (bit_idx_q == SB_LAST) begin
              complete  = 1'b1;
              bit_idx_d = '0;
              state_d   = stop_err_d ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (rx_sync) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = overrun_q;
    if (complete) begin
      if (!m_valid_q || m_ready) begin
        m_data_d     = shreg_d;
        m_valid_d    = 1'b1;
        parity_err_d = par_err_d;
        frame_err_d  = stop_err_d;
        break_det_d  = brk_d;
        if (m_valid_q) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vote_q       <= 3'b111;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      brk_q        <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vote_q       <= vote_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      brk_q        <= brk_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DATA_BITS, 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter OVS, 16, baud_tick periods per bit; even, minimum 4.
REQ-003 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 clk  input  1  system clock; all flops SHALL be clocked on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 baud_tick  input  1  one-clk strobe at OVS x baud rate; gates all receive-FSM updates.
REQ-008 rx  input  1  asynchronous serial line; idle high.
REQ-009 m_data  output  DATA_BITS  received word, LSB first on the line, registered.
REQ-010 m_valid  output  1  m_data and status flags hold a completed frame.
REQ-011 m_ready  input  1  consumer accepts the frame in any clk cycle where m_valid=1.
REQ-012 parity_err, frame_err, break_det  output  1 each  status of the frame in m_data.
REQ-013 overrun  output  1  sticky; a frame was dropped while m_valid was held.

Function
REQ-014 rx SHALL pass through a two-flop synchronizer; a 3-deep shift register of synchronized samples SHALL update on every baud_tick.
REQ-015 Every bit decision SHALL be the 2-of-3 majority of that shift register at the sample tick.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BRK_WAIT, with a tick counter cnt of width clog2(OVS).
REQ-017 In IDLE, a synchronized low at a tick SHALL enter START with cnt=0.
REQ-018 In START at cnt=OVS/2-1: vote 0 enters DATA with cnt=0; vote 1 returns to IDLE (glitch reject).
REQ-019 In DATA, PARITY and STOP, the sample tick SHALL be cnt=OVS-1, where cnt wraps to 0.
REQ-020 DATA SHALL shift in DATA_BITS samples LSB first, then enter PARITY if PARITY!=0, else STOP.
REQ-021 PARITY SHALL compare the sampled bit against XOR(data) (even) or its inverse (odd).
REQ-022 STOP SHALL sample STOP_BITS bits; frame_err=1 if any stop sample is 0.
REQ-023 break_det SHALL be 1 when all data bits, the parity bit (if present) and the first stop bit are 0.
REQ-024 Completion occurs at the final stop sample tick; state goes to IDLE, or to BRK_WAIT if frame_err=1.
REQ-025 BRK_WAIT SHALL return to IDLE only after a tick with synchronized rx=1.
REQ-026 On completion with m_valid=0 or m_ready=1, m_data and flags SHALL load on that clk edge, with m_valid=1.
REQ-027 On completion with m_valid=1 and m_ready=0, the new frame SHALL be dropped, old data kept, and overrun set to 1.
REQ-028 A handshake without a simultaneous completion SHALL clear m_valid and overrun on the next edge; this is independent of baud_tick.

Reset
REQ-029 Reset SHALL force state IDLE, cnt=0, the vote register to 3'b111 and m_data=0.
REQ-030 Reset SHALL force m_valid, parity_err, frame_err, break_det and overrun to 0.
REQ-031 Reset SHALL have priority over baud_tick, completion and handshake.
REQ-032 A frame in progress at reset SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the state encoding and the PARITY_NONE/EVEN/ODD constants.
REQ-034 The synchronizer SHALL be the existing data_sync sub-module, instantiated once.

Verification (8N1, OVS=16 unless stated)
REQ-035 Send 0xA5 -> m_data=0xA5, m_valid=1 and all flags 0 one clk after the final stop sample tick.
REQ-036 8E1: send 0x03 with parity bit 1 -> parity_err=1, m_data=0x03; with parity bit 0 -> parity_err=0.
REQ-037 Drive rx low for 4 ticks, then high -> no m_valid and the FSM back in IDLE.
REQ-038 Drive rx low for 20 bit times, then send 0x55 -> exactly two frames: {0x00, frame_err=1, break_det=1}, then {0x55, no flags}.
REQ-039 Send 0x11 then 0x22 with m_ready=0 -> m_data=0x11 and overrun=1; raise m_ready -> m_valid=0 and overrun=0 next clk.
REQ-040 Assert reset in the middle of DATA, release it, then send 0x3C -> all outputs 0 during reset, then m_data=0x3C clean.
